// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings and MEM-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational data-path helper for the MEM stage: access legality, store lane
// replication/strobes and load byte/half extraction with sign or zero extension.
module load_store_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        legal_o,
  output logic        illegal_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    legal_o = 1'b0;
    if (mem_read_i && !mem_write_i) begin
      case (funct3_i)
        F3_LB, F3_LBU: legal_o = 1'b1;
        F3_LH, F3_LHU: legal_o = ~addr_i[0];
        F3_LW:         legal_o = (addr_i[1:0] == 2'b00);
        default:       legal_o = 1'b0;
      endcase
    end else if (mem_write_i && !mem_read_i) begin
      case (funct3_i)
        F3_SB:   legal_o = 1'b1;
        F3_SH:   legal_o = ~addr_i[0];
        F3_SW:   legal_o = (addr_i[1:0] == 2'b00);
        default: legal_o = 1'b0;
      endcase
    end
    illegal_o = (mem_read_i | mem_write_i) & ~legal_o;
  end

  // Sub-word stores replicate the data across all lanes; the strobe picks the lane.
  always_comb begin
    wdata_o = store_data_i;
    wstrb_o = 4'b0000;
    if (mem_write_i) begin
      case (funct3_i)
        F3_SB: begin
          wdata_o = {4{store_data_i[7:0]}};
          wstrb_o = 4'b0001 << addr_i[1:0];
        end
        F3_SH: begin
          wdata_o = {2{store_data_i[15:0]}};
          wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        F3_SW:   wstrb_o = 4'b1111;
        default: wstrb_o = 4'b0000;
      endcase
    end
  end

  always_comb begin
    shifted = rdata_i >> {addr_i[1:0], 3'b000};
    case (funct3_i)
      F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data_o = {24'h000000, shifted[7:0]};
      F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data_o = {16'h0000, shifted[15:0]};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data bus with wait-state timeout, resolves the branch
// redirect, stalls the front end while an access is outstanding and owns MEM/WB.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmem_pc_target,
  input  logic [31:0] exmem_ula_result,
  input  logic [31:0] exmem_reg_data2,
  input  logic [4:0]  exmem_rd,
  input  logic [2:0]  exmem_funct3,
  input  logic        exmem_RegWrite,
  input  logic        exmem_MemRead,
  input  logic        exmem_MemWrite,
  input  logic        exmem_MemtoReg,
  input  logic        exmem_Branch,
  input  logic        exmem_zero_flag,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_redirect,
  output logic [31:0] memwb_read_data,
  output logic [31:0] memwb_ula_result,
  output logic [4:0]  memwb_rd,
  output logic        memwb_RegWrite,
  output logic        memwb_MemtoReg,
  output logic        mem_fault
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  logic        legal;
  logic        illegal;
  logic [31:0] load_data;
  logic        ack_eff;
  logic        abort;

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] ula_q, ula_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic        fault_q, fault_d;

  load_store_align u_align (
    .funct3_i     (exmem_funct3),
    .addr_i       (exmem_ula_result),
    .mem_read_i   (exmem_MemRead),
    .mem_write_i  (exmem_MemWrite),
    .store_data_i (exmem_reg_data2),
    .rdata_i      (dmem_rdata),
    .legal_o      (legal),
    .illegal_o    (illegal),
    .wdata_o      (dmem_wdata),
    .wstrb_o      (dmem_wstrb),
    .load_data_o  (load_data)
  );

  // done_q marks the cycle after a timeout: the same EX/MEM entry must not re-request.
  assign abort     = done_q;
  assign dmem_req  = legal & ~done_q;
  assign ack_eff   = dmem_ack & dmem_req;
  assign dmem_we   = exmem_MemWrite;
  assign dmem_addr = {exmem_ula_result[31:2], 2'b00};
  assign mem_stall = legal & ~ack_eff & ~abort;

  assign pc_src      = exmem_Branch & exmem_zero_flag & ~mem_stall;
  assign pc_redirect = mem_stall ? 32'h0 : exmem_pc_target;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (dmem_req && !ack_eff) begin
          state_d = StWait;
          cnt_d   = 8'd1;
        end
      end
      StWait: begin
        if (ack_eff) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    ula_d       = ula_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    if (mem_stall) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      rd_d        = exmem_rd;
      ula_d       = exmem_ula_result;
      memtoreg_d  = exmem_MemtoReg;
      regwrite_d  = exmem_RegWrite & ~illegal & ~abort;
      read_data_d = (exmem_MemRead & ack_eff) ? load_data : 32'h0;
    end
    fault_d = illegal | abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      done_q      <= 1'b0;
      read_data_q <= 32'h0;
      ula_q       <= 32'h0;
      rd_q        <= 5'd0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
      ula_q       <= ula_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      fault_q     <= fault_d;
    end
  end

  assign memwb_read_data  = read_data_q;
  assign memwb_ula_result = ula_q;
  assign memwb_rd         = rd_q;
  assign memwb_RegWrite   = regwrite_q;
  assign memwb_MemtoReg   = memtoreg_q;
  assign mem_fault        = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: expected MEM/WB contents are queued when an
// EX/MEM entry is driven and checked when the stage releases it.
module tb_mem_access_stage;
  import riscv_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exmem_pc_target, exmem_ula_result, exmem_reg_data2;
  logic [4:0]  exmem_rd;
  logic [2:0]  exmem_funct3;
  logic        exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemtoReg;
  logic        exmem_Branch, exmem_zero_flag;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        mem_stall, pc_src;
  logic [31:0] pc_redirect, memwb_read_data, memwb_ula_result;
  logic [4:0]  memwb_rd;
  logic        memwb_RegWrite, memwb_MemtoReg, mem_fault;

  int tests_run = 0;
  int failures  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] ula;
    logic [31:0] rdata;
    logic        regw;
    logic        m2r;
    logic        fault;
  } wb_t;

  wb_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .exmem_pc_target  (exmem_pc_target),
    .exmem_ula_result (exmem_ula_result),
    .exmem_reg_data2  (exmem_reg_data2),
    .exmem_rd         (exmem_rd),
    .exmem_funct3     (exmem_funct3),
    .exmem_RegWrite   (exmem_RegWrite),
    .exmem_MemRead    (exmem_MemRead),
    .exmem_MemWrite   (exmem_MemWrite),
    .exmem_MemtoReg   (exmem_MemtoReg),
    .exmem_Branch     (exmem_Branch),
    .exmem_zero_flag  (exmem_zero_flag),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_rdata       (dmem_rdata),
    .dmem_ack         (dmem_ack),
    .mem_stall        (mem_stall),
    .pc_src           (pc_src),
    .pc_redirect      (pc_redirect),
    .memwb_read_data  (memwb_read_data),
    .memwb_ula_result (memwb_ula_result),
    .memwb_rd         (memwb_rd),
    .memwb_RegWrite   (memwb_RegWrite),
    .memwb_MemtoReg   (memwb_MemtoReg),
    .mem_fault        (mem_fault)
  );

  task automatic drive_nop();
    exmem_ula_result = 32'h0;
    exmem_reg_data2  = 32'h0;
    exmem_rd         = 5'd0;
    exmem_funct3     = 3'b000;
    exmem_RegWrite   = 1'b0;
    exmem_MemRead    = 1'b0;
    exmem_MemWrite   = 1'b0;
    exmem_MemtoReg   = 1'b0;
    dmem_ack         = 1'b0;
    dmem_rdata       = 32'h0;
  endtask

  // Called just after a falling edge; returns just after the falling edge that follows
  // the MEM/WB capture of this entry. ack_delay < 0 means the memory never acks.
  task automatic run_entry(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic rd_en, input logic wr_en,
                           input logic regw, input logic [4:0] rd, input int ack_delay,
                           input logic [31:0] rdata, input logic exp_legal,
                           input logic exp_timeout, input int exp_stalls,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                           input logic [31:0] exp_load);
    wb_t  e;
    wb_t  got;
    int   stalls;
    logic st;
    logic released;
    exmem_funct3     = f3;
    exmem_ula_result = addr;
    exmem_reg_data2  = sdata;
    exmem_MemRead    = rd_en;
    exmem_MemWrite   = wr_en;
    exmem_MemtoReg   = rd_en;
    exmem_RegWrite   = regw;
    exmem_rd         = rd;
    e.rd    = rd;
    e.ula   = addr;
    e.regw  = regw & exp_legal & ~exp_timeout;
    e.m2r   = rd_en;
    e.rdata = (rd_en & exp_legal & ~exp_timeout) ? exp_load : 32'h0;
    e.fault = ~exp_legal | exp_timeout;
    sb_q.push_back(e);
    stalls   = 0;
    released = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      dmem_ack   = (ack_delay == cyc);
      dmem_rdata = rdata;
      #1;
      st = mem_stall;
      if (cyc == 0) begin
        tests_run++;
        if (dmem_req !== exp_legal) begin
          failures++;
          $display("FAIL %s req: got %b want %b", name, dmem_req, exp_legal);
        end
        if (exp_legal) begin
          tests_run++;
          if ({dmem_addr, dmem_we, dmem_wstrb} !== {addr[31:2], 2'b00, wr_en, exp_wstrb}) begin
            failures++;
            $display("FAIL %s bus: got addr %h we %b strb %b want addr %h we %b strb %b",
                     name, dmem_addr, dmem_we, dmem_wstrb, {addr[31:2], 2'b00}, wr_en,
                     exp_wstrb);
          end
          if (wr_en) begin
            tests_run++;
            if (dmem_wdata !== exp_wdata) begin
              failures++;
              $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, exp_wdata);
            end
          end
        end
      end
      if (exp_timeout && cyc == exp_stalls) begin
        tests_run++;
        if (dmem_req !== 1'b0 || st !== 1'b0) begin
          failures++;
          $display("FAIL %s abort cycle: got req %b stall %b want 0 0", name, dmem_req, st);
        end
      end
      if (st === 1'b1) begin
        stalls++;
        tests_run++;
        if (pc_src !== 1'b0 || pc_redirect !== 32'h0) begin
          failures++;
          $display("FAIL %s pc during stall: got %b %h want 0 0", name, pc_src, pc_redirect);
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (st !== 1'b1) begin
        released = 1'b1;
        break;
      end
      tests_run++;
      if (memwb_RegWrite !== 1'b0 || memwb_MemtoReg !== 1'b0) begin
        failures++;
        $display("FAIL %s bubble: got RegWrite %b MemtoReg %b want 0 0", name,
                 memwb_RegWrite, memwb_MemtoReg);
      end
    end
    dmem_ack = 1'b0;
    tests_run++;
    if (!released || stalls != exp_stalls) begin
      failures++;
      $display("FAIL %s stall count: got %0d (released %b) want %0d", name, stalls, released,
               exp_stalls);
    end
    tests_run++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
    end else begin
      e = sb_q.pop_front();
      got.rd    = memwb_rd;
      got.ula   = memwb_ula_result;
      got.rdata = memwb_read_data;
      got.regw  = memwb_RegWrite;
      got.m2r   = memwb_MemtoReg;
      got.fault = mem_fault;
      if ({got.rd, got.ula, got.rdata, got.regw, got.m2r, got.fault} !==
          {e.rd, e.ula, e.rdata, e.regw, e.m2r, e.fault}) begin
        failures++;
        $display("FAIL %s memwb: got rd %0d ula %h data %h rw %b m2r %b flt %b want rd %0d ula %h data %h rw %b m2r %b flt %b",
                 name, got.rd, got.ula, got.rdata, got.regw, got.m2r, got.fault,
                 e.rd, e.ula, e.rdata, e.regw, e.m2r, e.fault);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exmem_pc_target = 32'h0;
    exmem_Branch    = 1'b0;
    exmem_zero_flag = 1'b0;
    drive_nop();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({memwb_read_data, memwb_ula_result, memwb_rd, memwb_RegWrite, memwb_MemtoReg,
         mem_fault, dmem_req, mem_stall} !== 74'h0) begin
      failures++;
      $display("FAIL reset state: got data %h ula %h rd %0d rw %b m2r %b flt %b req %b stall %b want all 0",
               memwb_read_data, memwb_ula_result, memwb_rd, memwb_RegWrite, memwb_MemtoReg,
               mem_fault, dmem_req, mem_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    run_entry("sw_zero_wait", F3_SW, 32'h100, 32'hDEADBEEF, 0, 1, 0, 5'd0, 0, 32'h0, 1, 0, 0,
              32'hDEADBEEF, 4'b1111, 32'h0);
    run_entry("sb_103", F3_SB, 32'h103, 32'h000000A5, 0, 1, 0, 5'd0, 0, 32'h0, 1, 0, 0,
              32'hA5A5A5A5, 4'b1000, 32'h0);
    run_entry("lb_103", F3_LB, 32'h103, 32'h0, 1, 0, 1, 5'd3, 0, 32'hA5000000, 1, 0, 0,
              32'h0, 4'b0000, 32'hFFFFFFA5);
    run_entry("lbu_103", F3_LBU, 32'h103, 32'h0, 1, 0, 1, 5'd4, 0, 32'hA5000000, 1, 0, 0,
              32'h0, 4'b0000, 32'h000000A5);
    run_entry("sh_102", F3_SH, 32'h102, 32'h00001234, 0, 1, 0, 5'd0, 0, 32'h0, 1, 0, 0,
              32'h12341234, 4'b1100, 32'h0);
    run_entry("lh_102", F3_LH, 32'h102, 32'h0, 1, 0, 1, 5'd5, 0, 32'h80010000, 1, 0, 0,
              32'h0, 4'b0000, 32'hFFFF8001);
    run_entry("lhu_102", F3_LHU, 32'h102, 32'h0, 1, 0, 1, 5'd6, 0, 32'h80010000, 1, 0, 0,
              32'h0, 4'b0000, 32'h00008001);
  endtask

  task automatic test_wait_states();
    run_entry("lw_wait3", F3_LW, 32'h200, 32'h0, 1, 0, 1, 5'd9, 3, 32'hCAFEF00D, 1, 0, 3,
              32'h0, 4'b0000, 32'hCAFEF00D);
  endtask

  task automatic test_illegal();
    run_entry("lh_misaligned", F3_LH, 32'h101, 32'h0, 1, 0, 1, 5'd10, -1, 32'h0, 0, 0, 0,
              32'h0, 4'b0000, 32'h0);
    drive_nop();
    @(negedge clk);
    tests_run++;
    if (mem_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault pulse width: got %b want 0", mem_fault);
    end
    run_entry("load_f3_011", 3'b011, 32'h0, 32'h0, 1, 0, 1, 5'd11, -1, 32'h0, 0, 0, 0,
              32'h0, 4'b0000, 32'h0);
    run_entry("store_f3_100", 3'b100, 32'h20, 32'h55, 0, 1, 0, 5'd0, -1, 32'h0, 0, 0, 0,
              32'h0, 4'b0000, 32'h0);
    run_entry("sw_misaligned", F3_SW, 32'h22, 32'h55, 0, 1, 0, 5'd0, -1, 32'h0, 0, 0, 0,
              32'h0, 4'b0000, 32'h0);
  endtask

  task automatic test_timeout();
    // Late ack arrives in the abort cycle, while req is low.
    run_entry("lw_timeout", F3_LW, 32'h400, 32'h0, 1, 0, 1, 5'd7, int'(TO) + 1, 32'h12345678,
              1, 1, int'(TO) + 1, 32'h0, 4'b0000, 32'h0);
    run_entry("after_timeout", F3_LW, 32'h404, 32'h0, 1, 0, 1, 5'd8, 0, 32'h0BADF00D, 1, 0, 0,
              32'h0, 4'b0000, 32'h0BADF00D);
  endtask

  task automatic test_back_to_back();
    run_entry("b2b_lw0", F3_LW, 32'h10, 32'h0, 1, 0, 1, 5'd12, 0, 32'h11111111, 1, 0, 0,
              32'h0, 4'b0000, 32'h11111111);
    run_entry("b2b_lw1", F3_LW, 32'h14, 32'h0, 1, 0, 1, 5'd13, 1, 32'h22222222, 1, 0, 1,
              32'h0, 4'b0000, 32'h22222222);
    run_entry("b2b_sw", F3_SW, 32'h18, 32'h33333333, 0, 1, 0, 5'd0, 0, 32'h0, 1, 0, 0,
              32'h33333333, 4'b1111, 32'h0);
  endtask

  task automatic test_branch();
    drive_nop();
    exmem_pc_target = 32'h40;
    exmem_Branch    = 1'b1;
    exmem_zero_flag = 1'b1;
    #1;
    tests_run++;
    if (pc_src !== 1'b1 || pc_redirect !== 32'h40) begin
      failures++;
      $display("FAIL branch taken: got %b %h want 1 00000040", pc_src, pc_redirect);
    end
    exmem_zero_flag = 1'b0;
    #1;
    tests_run++;
    if (pc_src !== 1'b0) begin
      failures++;
      $display("FAIL branch not taken: got %b want 0", pc_src);
    end
    exmem_zero_flag = 1'b1;
    run_entry("lw_branch_stall", F3_LW, 32'h60, 32'h0, 1, 0, 1, 5'd14, 2, 32'h76543210, 1, 0,
              2, 32'h0, 4'b0000, 32'h76543210);
    exmem_Branch    = 1'b0;
    exmem_zero_flag = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    exmem_funct3     = F3_LW;
    exmem_ula_result = 32'h300;
    exmem_MemRead    = 1'b1;
    exmem_MemtoReg   = 1'b1;
    exmem_RegWrite   = 1'b1;
    exmem_rd         = 5'd15;
    dmem_ack         = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    drive_nop();
    #1;
    tests_run++;
    if ({dmem_req, mem_stall, mem_fault, memwb_read_data, memwb_ula_result, memwb_rd,
         memwb_RegWrite, memwb_MemtoReg} !== 74'h0) begin
      failures++;
      $display("FAIL reset mid-wait: got req %b stall %b flt %b data %h ula %h rd %0d rw %b m2r %b want all 0",
               dmem_req, mem_stall, mem_fault, memwb_read_data, memwb_ula_result, memwb_rd,
               memwb_RegWrite, memwb_MemtoReg);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault after reset: got %b want 0", mem_fault);
    end
    run_entry("lw_after_reset", F3_LW, 32'h304, 32'h0, 1, 0, 1, 5'd16, 1, 32'hA1B2C3D4, 1, 0, 1,
              32'h0, 4'b0000, 32'hA1B2C3D4);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait_states();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_branch();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the five-stage RISC-V pipeline: consumes the EX/MEM register outputs, performs loads and stores over a req/ack data-memory bus with wait-state and timeout handling, resolves the taken-branch redirect, and owns the MEM/WB register. Stalls the front of the pipeline while a memory access is outstanding and inserts a WB bubble for each stall cycle.

## Interface
- TIMEOUT_CYCLES, 16: maximum WAIT-state cycles before the access is aborted (range 1..255).
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- exmem_pc_target, exmem_ula_result, exmem_reg_data2  in  32 each  branch target, address/ALU result, store data
- exmem_rd  in  5;  exmem_funct3  in  3
- exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemtoReg, exmem_Branch, exmem_zero_flag  in  1 each
- dmem_req  out  1  access request, held until ack or abort
- dmem_we  out  1;  dmem_addr  out  32 (word aligned, [1:0]=0);  dmem_wdata  out  32;  dmem_wstrb  out  4
- dmem_rdata  in  32;  dmem_ack  in  1  completion, valid only while dmem_req=1
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1;  pc_redirect  out  32  branch redirect
- memwb_read_data, memwb_ula_result  out  32;  memwb_rd  out  5;  memwb_RegWrite, memwb_MemtoReg  out  1
- mem_fault  out  1  registered one-cycle pulse: misaligned, illegal funct3, or timeout

## Operation
- access = MemRead | MemWrite. Legal check on funct3 and addr[1:0]: byte (000/100 load, 000 store) any offset; half (001/101 load, 001 store) requires addr[0]=0; word (010) requires addr[1:0]=0. Other funct3 values, stores with funct3 bit2 set, or MemRead&MemWrite both set: illegal.
- Illegal access: no dmem_req, no stall; MEM/WB captures with RegWrite=0; mem_fault=1 next cycle.
- Legal access: dmem_req=1, dmem_we=MemWrite, dmem_addr={addr[31:2],2'b00}.
- Stores: SB replicates byte to all lanes, wstrb=0001<<addr[1:0]; SH replicates halfword, wstrb=0011 or 1100; SW wstrb=1111. wstrb=0000 on reads.
- Loads: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- FSM: IDLE, WAIT. IDLE: legal access & !ack -> WAIT, counter=1. WAIT: ack -> IDLE; counter==TIMEOUT_CYCLES & !ack -> IDLE with abort (mem_fault next cycle, RegWrite=0 into MEM/WB); else counter+1. Counter is 8 bits, cleared on entry to IDLE.
- Abort holds dmem_req low for one cycle (state ABORT-free: a one-cycle done flag blocks re-request of the same EX/MEM entry); ack while dmem_req=0 ignored.
- mem_stall = legal access & !dmem_ack & !abort (combinational).
- pc_src = exmem_Branch & exmem_zero_flag; pc_redirect = exmem_pc_target; both combinational, forced 0 while mem_stall.
- MEM/WB: each clock, if mem_stall load bubble (RegWrite=0, MemtoReg=0, other fields hold); else capture rd, ula_result, MemtoReg, RegWrite (gated by legality/abort), read_data (extracted dmem_rdata on completing load, else 0).

## Timing
- Reset: state IDLE, counter 0, done 0, all memwb_* 0, mem_fault 0. Combinational outputs follow inputs during reset with state IDLE.
- Zero-wait memory (ack in request cycle): no stall; MEM/WB updated next edge.
- N wait cycles: mem_stall high N cycles; completion in the cycle ack arrives; MEM/WB updated next edge.
- Timeout: stall high TIMEOUT_CYCLES+1 cycles, then released; mem_fault pulses the cycle after release.
- Reset mid-access: req drops immediately, state IDLE, no fault.
- Back-to-back accesses: new request permitted the cycle after completion.

## Structure
- Shared package riscv_pkg: funct3 load/store constants (LB..LHU, SB..SW), FSM state encoding.
- Sub-module load_store_align: combinational store lane/strobe generation, load extraction/extension, legality check. FSM, counter and MEM/WB register in the top.

## Test plan
- SW addr 0x100 data 0xDEADBEEF, zero-wait ack -> wstrb 1111, addr 0x100, mem_stall never high.
- SB addr 0x103 data 0x000000A5 -> wdata 0xA5A5A5A5, wstrb 1000; LB same addr rdata 0xA5000000 -> memwb_read_data 0xFFFFFFA5; LBU -> 0x000000A5.
- LW with ack after 3 cycles -> mem_stall high 3 cycles, 3 bubbles (memwb_RegWrite=0), then data captured.
- LH addr 0x101 -> no dmem_req, memwb_RegWrite=0, mem_fault pulse one cycle later.
- No ack, TIMEOUT_CYCLES=4 -> stall 5 cycles, req drops, mem_fault pulse, RegWrite=0; late ack ignored.
- Branch=1, zero_flag=1, target 0x40 -> pc_src=1, pc_redirect 0x40; same during stall -> pc_src=0; rst mid-WAIT -> req low, outputs zero.
